// File: rtl/noc_pkg.sv
// Shared definitions for the NoC PE network interface: flit field layout,
// TX state encoding and a flit builder for the default node configuration.
package noc_pkg;

    localparam int NOC_X_SIZE     = 2;
    localparam int NOC_Y_SIZE     = 2;
    localparam int NOC_DATA_WIDTH = 8;

    localparam int DST_Y_LSB  = 0;
    localparam int DST_X_LSB  = NOC_Y_SIZE;
    localparam int SRC_Y_LSB  = NOC_X_SIZE + NOC_Y_SIZE;
    localparam int SRC_X_LSB  = SRC_Y_LSB + NOC_Y_SIZE;
    localparam int DATA_LSB   = 2 * NOC_X_SIZE + 2 * NOC_Y_SIZE;
    localparam int FLIT_WIDTH = DATA_LSB + NOC_DATA_WIDTH;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

    function automatic logic [FLIT_WIDTH-1:0] make_flit(
        input logic [NOC_DATA_WIDTH-1:0] data,
        input logic [NOC_X_SIZE-1:0]     sx,
        input logic [NOC_Y_SIZE-1:0]     sy,
        input logic [NOC_X_SIZE-1:0]     dx,
        input logic [NOC_Y_SIZE-1:0]     dy
    );
        return {data, sx, sy, dx, dy};
    endfunction

endpackage

// File: rtl/noc_ni_fifo.sv
// Synchronous FIFO with asynchronous active-low clear; DEPTH must be a power of 2.
module noc_ni_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;
    assign dout_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    always_comb begin
        count_d = count_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            count_q <= count_d;
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/noc_pe_interface.sv
// Network interface between a NoC switch PE port and a neuron PE: RX ejection
// buffer with address check, TX packetizer fanning each word out to DEST_LIST.
module noc_pe_interface
    import noc_pkg::*;
#(
    parameter int X_COORD     = 3,
    parameter int Y_COORD     = 1,
    parameter int X_SIZE      = 2,
    parameter int Y_SIZE      = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int TOTAL_WIDTH = 2 * X_SIZE + 2 * Y_SIZE + DATA_WIDTH,
    parameter int RX_DEPTH    = 4,
    parameter int NUM_DEST    = 2,
    parameter logic [NUM_DEST*(X_SIZE+Y_SIZE)-1:0] DEST_LIST = 8'h8D
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   i_noc_valid,
    input  logic [TOTAL_WIDTH-1:0] i_noc_data,
    output logic                   o_noc_ready,
    output logic                   o_noc_valid,
    output logic [TOTAL_WIDTH-1:0] o_noc_data,
    input  logic                   i_noc_ready,
    output logic                   o_pe_valid,
    output logic [DATA_WIDTH-1:0]  o_pe_data,
    output logic [X_SIZE-1:0]      o_pe_src_x,
    output logic [Y_SIZE-1:0]      o_pe_src_y,
    input  logic                   i_pe_ready,
    input  logic                   i_pe_valid,
    input  logic [DATA_WIDTH-1:0]  i_pe_data,
    output logic                   o_pe_ready,
    output logic                   o_rx_drop
);

    localparam int CW     = X_SIZE + Y_SIZE;
    localparam int FW     = DATA_WIDTH + CW;
    localparam int IDX_W  = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;
    localparam logic [X_SIZE-1:0] MY_X = X_SIZE'(X_COORD);
    localparam logic [Y_SIZE-1:0] MY_Y = Y_SIZE'(Y_COORD);

    logic                         rx_accept_s, rx_hit_s, rx_push_s, rx_pop_s;
    logic                         rx_full_s, rx_empty_s;
    logic [FW-1:0]                rx_head_s;
    logic [$clog2(RX_DEPTH):0]    rx_count_s;
    logic                         drop_q;

    tx_state_e                    state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [DATA_WIDTH-1:0]        hold_q, hold_d;
    logic                         pe_ready_q;
    logic [CW-1:0]                dest_s;

    assign o_noc_ready = ~rx_full_s;
    assign rx_accept_s = i_noc_valid & o_noc_ready;
    assign rx_hit_s    = (i_noc_data[CW-1:0] == {MY_X, MY_Y});
    assign rx_push_s   = rx_accept_s & rx_hit_s;
    assign o_pe_valid  = (rx_count_s != '0);
    assign rx_pop_s    = ~rx_empty_s & i_pe_ready;

    // Only {src, data} is buffered; dst is known to be this node.
    noc_ni_fifo #(
        .WIDTH (FW),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rstn),
        .push_i  (rx_push_s),
        .pop_i   (rx_pop_s),
        .din_i   (i_noc_data[TOTAL_WIDTH-1:CW]),
        .dout_o  (rx_head_s),
        .full_o  (rx_full_s),
        .empty_o (rx_empty_s),
        .count_o (rx_count_s)
    );

    assign o_pe_data  = rx_head_s[FW-1:CW];
    assign o_pe_src_x = rx_head_s[CW-1:Y_SIZE];
    assign o_pe_src_y = rx_head_s[Y_SIZE-1:0];
    assign o_rx_drop  = drop_q;

    assign dest_s      = DEST_LIST[idx_q*CW +: CW];
    assign o_noc_valid = (state_q == TX_SEND);
    assign o_noc_data  = {hold_q, MY_X, MY_Y, dest_s};
    assign o_pe_ready  = pe_ready_q;

    // TX next-state: one flit per DEST_LIST entry, advancing only on acceptance.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        case (state_q)
            TX_IDLE: begin
                if (i_pe_valid && pe_ready_q) begin
                    state_d = TX_SEND;
                    idx_d   = '0;
                    hold_d  = i_pe_data;
                end else begin
                    state_d = TX_IDLE;
                end
            end
            TX_SEND: begin
                if (i_noc_ready) begin
                    if (idx_q == IDX_W'(NUM_DEST - 1)) begin
                        state_d = TX_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = TX_SEND;
                end
            end
            default: begin
                state_d = TX_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // State, TX holding registers, registered PE-ready and drop pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= TX_IDLE;
            idx_q      <= '0;
            hold_q     <= '0;
            pe_ready_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hold_q     <= hold_d;
            pe_ready_q <= (state_d == TX_IDLE);
            drop_q     <= rx_accept_s & ~rx_hit_s;
        end
    end

endmodule

// File: tb/tb_noc_pe_interface.sv
// Directed self-checking bench for noc_pe_interface at node (3,1), DEST_LIST 8'h8D.
module tb_noc_pe_interface;
    import noc_pkg::*;

    logic        clk;
    logic        rstn;
    logic        i_noc_valid;
    logic [15:0] i_noc_data;
    logic        o_noc_ready;
    logic        o_noc_valid;
    logic [15:0] o_noc_data;
    logic        i_noc_ready;
    logic        o_pe_valid;
    logic [7:0]  o_pe_data;
    logic [1:0]  o_pe_src_x;
    logic [1:0]  o_pe_src_y;
    logic        i_pe_ready;
    logic        i_pe_valid;
    logic [7:0]  i_pe_data;
    logic        o_pe_ready;
    logic        o_rx_drop;

    int pass_cnt  = 0;
    int total_cnt = 0;

    noc_pe_interface dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_noc_valid (i_noc_valid),
        .i_noc_data  (i_noc_data),
        .o_noc_ready (o_noc_ready),
        .o_noc_valid (o_noc_valid),
        .o_noc_data  (o_noc_data),
        .i_noc_ready (i_noc_ready),
        .o_pe_valid  (o_pe_valid),
        .o_pe_data   (o_pe_data),
        .o_pe_src_x  (o_pe_src_x),
        .o_pe_src_y  (o_pe_src_y),
        .i_pe_ready  (i_pe_ready),
        .i_pe_valid  (i_pe_valid),
        .i_pe_data   (i_pe_data),
        .o_pe_ready  (o_pe_ready),
        .o_rx_drop   (o_rx_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rstn = 1'b0; i_noc_valid = 1'b0; i_noc_data = 16'h0000; i_noc_ready = 1'b0;
        i_pe_ready = 1'b0; i_pe_valid = 1'b0; i_pe_data = 8'h00;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({o_noc_valid, o_pe_valid, o_pe_ready, o_rx_drop, o_noc_ready} !== 5'b00001)
            $display("FAIL reset_outputs got %b want 00001",
                     {o_noc_valid, o_pe_valid, o_pe_ready, o_rx_drop, o_noc_ready});
        else pass_cnt++;
        rstn = 1'b1;
        #1;
        total_cnt++;
        if (o_pe_ready !== 1'b0) $display("FAIL pe_ready_before_edge got %b want 0", o_pe_ready);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (o_pe_ready !== 1'b1) $display("FAIL pe_ready_after_release got %b want 1", o_pe_ready);
        else pass_cnt++;
        // reset while a word is in flight
        i_pe_valid = 1'b1; i_pe_data = 8'h5A;
        @(negedge clk);
        i_pe_valid = 1'b0;
        total_cnt++;
        if (o_noc_valid !== 1'b1) $display("FAIL send_before_reset got %b want 1", o_noc_valid);
        else pass_cnt++;
        #2 rstn = 1'b0;
        #1;
        total_cnt++;
        if ({o_noc_valid, o_pe_ready} !== 2'b00)
            $display("FAIL async_reset_mid_send got %b want 00", {o_noc_valid, o_pe_ready});
        else pass_cnt++;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({o_noc_valid, o_pe_ready} !== 2'b01)
            $display("FAIL post_reset_idle got %b want 01", {o_noc_valid, o_pe_ready});
        else pass_cnt++;
    endtask

    task automatic test_tx_fanout;
        i_noc_ready = 1'b0;
        i_pe_valid = 1'b1; i_pe_data = 8'hA5;
        @(negedge clk);
        i_pe_valid = 1'b0;
        total_cnt++;
        if (o_pe_ready !== 1'b0) $display("FAIL tx_busy_ready got %b want 0", o_pe_ready);
        else pass_cnt++;
        for (int c = 0; c < 3; c++) begin
            total_cnt++;
            if ({o_noc_valid, o_noc_data} !== {1'b1, 16'hA5DD})
                $display("FAIL tx_hold_%0d got %b/%h want 1/a5dd", c, o_noc_valid, o_noc_data);
            else pass_cnt++;
            @(negedge clk);
        end
        i_noc_ready = 1'b1;
        total_cnt++;
        if ({o_noc_valid, o_noc_data} !== {1'b1, 16'hA5DD})
            $display("FAIL tx_flit0 got %b/%h want 1/a5dd", o_noc_valid, o_noc_data);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({o_noc_valid, o_noc_data} !== {1'b1, 16'hA5D8})
            $display("FAIL tx_flit1 got %b/%h want 1/a5d8", o_noc_valid, o_noc_data);
        else pass_cnt++;
        @(negedge clk);
        i_noc_ready = 1'b0;
        total_cnt++;
        if ({o_noc_valid, o_pe_ready} !== 2'b01)
            $display("FAIL tx_zero_bubble got %b want 01", {o_noc_valid, o_pe_ready});
        else pass_cnt++;
    endtask

    task automatic test_rx_backpressure;
        logic [11:0] exp_v [5];
        int n;
        for (int k = 1; k <= 5; k++) exp_v[k-1] = {8'(k), 2'(k % 4), 2'((k + 1) % 4)};
        i_pe_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            i_noc_valid = 1'b1;
            i_noc_data  = make_flit(8'(k), 2'(k % 4), 2'((k + 1) % 4), 2'd3, 2'd1);
            total_cnt++;
            if (o_noc_ready !== 1'b1) $display("FAIL rx_fill_ready_%0d got %b want 1", k, o_noc_ready);
            else pass_cnt++;
        end
        @(negedge clk);
        i_noc_data = make_flit(8'd5, 2'd1, 2'd2, 2'd3, 2'd1);
        total_cnt++;
        if (o_noc_ready !== 1'b0) $display("FAIL rx_full_ready got %b want 0", o_noc_ready);
        else pass_cnt++;
        i_pe_ready = 1'b1;
        n = 0;
        total_cnt++;
        if ({o_pe_valid, o_pe_data, o_pe_src_x, o_pe_src_y} !== {1'b1, exp_v[0]})
            $display("FAIL rx_order_0 got %b/%h want 1/%h", o_pe_valid,
                     {o_pe_data, o_pe_src_x, o_pe_src_y}, exp_v[0]);
        else pass_cnt++;
        n = 1;
        @(negedge clk);
        total_cnt++;
        if (o_noc_ready !== 1'b1) $display("FAIL rx_pop_admits_next got %b want 1", o_noc_ready);
        else pass_cnt++;
        total_cnt++;
        if ({o_pe_data, o_pe_src_x, o_pe_src_y} !== exp_v[1])
            $display("FAIL rx_order_1 got %h want %h", {o_pe_data, o_pe_src_x, o_pe_src_y}, exp_v[1]);
        else pass_cnt++;
        n = 2;
        @(negedge clk);
        i_noc_valid = 1'b0;
        for (int g = 0; g < 10 && n < 5; g++) begin
            if (o_pe_valid) begin
                total_cnt++;
                if ({o_pe_data, o_pe_src_x, o_pe_src_y} !== exp_v[n])
                    $display("FAIL rx_order_%0d got %h want %h", n,
                             {o_pe_data, o_pe_src_x, o_pe_src_y}, exp_v[n]);
                else pass_cnt++;
                n++;
            end
            @(negedge clk);
        end
        total_cnt++;
        if ({n[3:0], o_pe_valid} !== {4'd5, 1'b0})
            $display("FAIL rx_drain_count got %0d/%b want 5/0", n, o_pe_valid);
        else pass_cnt++;
        i_pe_ready = 1'b0;
    endtask

    task automatic test_misaddressed;
        @(negedge clk);
        i_noc_valid = 1'b1; i_noc_data = 16'h3C05;
        @(negedge clk);
        i_noc_valid = 1'b0;
        total_cnt++;
        if ({o_rx_drop, o_pe_valid} !== 2'b10)
            $display("FAIL drop_pulse got %b want 10", {o_rx_drop, o_pe_valid});
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({o_rx_drop, o_pe_valid, o_noc_ready} !== 3'b001)
            $display("FAIL drop_one_cycle got %b want 001", {o_rx_drop, o_pe_valid, o_noc_ready});
        else pass_cnt++;
    endtask

    task automatic test_latency_pushpop;
        i_pe_ready = 1'b0;
        i_noc_valid = 1'b1; i_noc_data = 16'h774D;
        #1;
        total_cnt++;
        if (o_pe_valid !== 1'b0) $display("FAIL no_bypass got %b want 0", o_pe_valid);
        else pass_cnt++;
        @(negedge clk);
        i_noc_data = 16'h884D;
        total_cnt++;
        if ({o_pe_valid, o_pe_data, o_pe_src_x, o_pe_src_y} !== {1'b1, 8'h77, 2'd1, 2'd0})
            $display("FAIL rx_latency got %b/%h/%0d/%0d want 1/77/1/0",
                     o_pe_valid, o_pe_data, o_pe_src_x, o_pe_src_y);
        else pass_cnt++;
        @(negedge clk);
        i_noc_data = 16'h994D; i_pe_ready = 1'b1;
        @(negedge clk);
        i_noc_valid = 1'b0;
        total_cnt++;
        if ({o_pe_valid, o_pe_data} !== {1'b1, 8'h88})
            $display("FAIL pushpop_head got %b/%h want 1/88", o_pe_valid, o_pe_data);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({o_pe_valid, o_pe_data} !== {1'b1, 8'h99})
            $display("FAIL pushpop_second got %b/%h want 1/99", o_pe_valid, o_pe_data);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (o_pe_valid !== 1'b0) $display("FAIL pushpop_count2 got %b want 0", o_pe_valid);
        else pass_cnt++;
        i_pe_ready = 1'b0;
    endtask

    task automatic test_concurrent;
        logic [15:0] tx_exp [2];
        int rn;
        int tn;
        tx_exp[0] = 16'h11DD; tx_exp[1] = 16'h11D8;
        rn = 0; tn = 0;
        i_pe_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            i_noc_valid = (c < 6);
            i_noc_data  = make_flit(8'(8'h20 + c), 2'(c % 4), 2'((c + 3) % 4), 2'd3, 2'd1);
            i_pe_valid  = (c == 0);
            i_pe_data   = 8'h11;
            i_noc_ready = (c % 2 == 1);
            #1;
            if (i_noc_valid) begin
                total_cnt++;
                if (o_noc_ready !== 1'b1) $display("FAIL conc_rx_ready_%0d got %b want 1", c, o_noc_ready);
                else pass_cnt++;
            end
            if (o_pe_valid && rn < 6) begin
                total_cnt++;
                if ({o_pe_data, o_pe_src_x, o_pe_src_y} !== {8'(8'h20 + rn), 2'(rn % 4), 2'((rn + 3) % 4)})
                    $display("FAIL conc_rx_%0d got %h want %h", rn, {o_pe_data, o_pe_src_x, o_pe_src_y},
                             {8'(8'h20 + rn), 2'(rn % 4), 2'((rn + 3) % 4)});
                else pass_cnt++;
                rn++;
            end
            if (o_noc_valid && i_noc_ready && tn < 2) begin
                total_cnt++;
                if (o_noc_data !== tx_exp[tn])
                    $display("FAIL conc_tx_%0d got %h want %h", tn, o_noc_data, tx_exp[tn]);
                else pass_cnt++;
                tn++;
            end
            @(negedge clk);
        end
        i_noc_valid = 1'b0; i_pe_valid = 1'b0; i_noc_ready = 1'b0;
        total_cnt++;
        if ({rn[3:0], tn[1:0], o_pe_valid, o_noc_valid, o_pe_ready} !== {4'd6, 2'd2, 3'b001})
            $display("FAIL conc_totals got rx=%0d tx=%0d pv=%b nv=%b pr=%b want 6/2/0/0/1",
                     rn, tn, o_pe_valid, o_noc_valid, o_pe_ready);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_tx_fanout();
        test_rx_backpressure();
        test_misaddressed();
        test_latency_pushpop();
        test_concurrent();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
